// File: rtl/rv_pkg.sv
// ============================================================================
//  Module      : rv_pkg
//  Description : RV32I opcode, funct3 and SYSTEM encodings shared by the
//                decode pipeline, plus the funct3 legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_PRIV     = 3'd0;
    localparam logic [2:0] F3_SYS_RSVD = 3'd4;
    localparam logic [2:0] F3_CSRRWI   = 3'd5;
    localparam logic [2:0] F3_CSRRSI   = 3'd6;
    localparam logic [2:0] F3_CSRRCI   = 3'd7;

    // ins[31:7] of the funct3==0 SYSTEM instructions
    localparam logic [24:0] F25_ECALL  = 25'h0000000;
    localparam logic [24:0] F25_EBREAK = 25'h0002000;
    localparam logic [24:0] F25_MRET   = 25'h0604000;

    localparam logic [11:0] MEPC_AR = 12'h341;

    typedef enum logic [1:0] {
        SYS_NONE   = 2'b00,
        SYS_MRET   = 2'b01,
        SYS_ECALL  = 2'b10,
        SYS_EBREAK = 2'b11
    } sys_e;

    function automatic logic f3_illegal(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_LOAD:   return f3 inside {3'd3, 3'd6, 3'd7};
            OPC_STORE:  return f3 >= 3'd3;
            OPC_BRANCH: return f3 inside {3'd2, 3'd3};
            OPC_SYSTEM: return f3 == F3_SYS_RSVD;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_imm_gen.sv
// ============================================================================
//  Module      : rv_imm_gen
//  Description : Combinational immediate format mux, sign-extended to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_ins,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_imm
);

    logic signed [11:0] w_i12;
    logic signed [11:0] w_s12;
    logic signed [12:0] w_b13;
    logic signed [20:0] w_j21;
    logic signed [31:0] w_u32;
    logic [XLEN-1:0]    w_imm_u;

    assign w_i12   = i_ins[31:20];
    assign w_s12   = {i_ins[31:25], i_ins[11:7]};
    assign w_b13   = {i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
    assign w_j21   = {i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
    assign w_u32   = {i_ins[31:12], 12'b0};
    assign w_imm_u = XLEN'(w_u32);

    always_comb begin
        o_imm = '0;
        case (i_ins[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: o_imm = XLEN'(w_i12);
            OPC_STORE:                     o_imm = XLEN'(w_s12);
            OPC_BRANCH:                    o_imm = XLEN'(w_b13);
            OPC_JAL:                       o_imm = XLEN'(w_j21);
            OPC_LUI:                       o_imm = w_imm_u;
            OPC_AUIPC:                     o_imm = w_imm_u + i_pc;
            OPC_SYSTEM: begin
                // CSR*I forms carry rs1 as an unsigned 5-bit zimm
                if (i_ins[14:12] inside {F3_CSRRWI, F3_CSRRSI, F3_CSRRCI})
                    o_imm = XLEN'(i_ins[19:15]);
            end
            default:                       o_imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv_id_pipe.sv
// ============================================================================
//  Module      : rv_id_pipe
//  Description : Registered RV32I decode stage with valid/ready handshakes,
//                load-use bubble insertion, flush and illegal detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_id_pipe
    import rv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int HAZARD_EN  = 1,
    parameter int ILLEGAL_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_if2id_valid,
    output logic            o_if2id_ready,
    input  logic [XLEN-1:0] i_if2id_addr,
    input  logic [31:0]     i_if2id_ins,
    input  logic            i_wash_en,
    input  logic            i_ex_ready,
    output logic            o_id2ex_valid,
    output logic [XLEN-1:0] o_id2ex_pc,
    output logic [6:0]      o_id2ex_op_code,
    output logic [4:0]      o_id2ex_rd_addr,
    output logic [4:0]      o_id2ex_op0_addr,
    output logic [4:0]      o_id2ex_op1_addr,
    output logic [2:0]      o_id2ex_op_func3,
    output logic [6:0]      o_id2ex_op_func7,
    output logic [XLEN-1:0] o_id2ex_op_imm,
    output logic            o_id2ex_mem_wr_en,
    output logic            o_id2ex_mem_rd_en,
    output logic            o_id2ex_reg_wr_en,
    output logic            o_id2ex_reg_rd_en,
    output logic [11:0]     o_id2ex_csr_addr,
    output logic [1:0]      o_id2ex_sys,
    output logic            o_id2ex_illegal
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic            mem_wr;
        logic            mem_rd;
        logic            reg_wr;
        logic            reg_rd;
        logic [11:0]     csr;
        logic [1:0]      sys;
        logic            illegal;
    } id2ex_t;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_imm;
    logic            w_use_rd;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_known;
    logic            w_mem_rd;
    logic            w_mem_wr;
    logic [11:0]     w_csr;
    logic [1:0]      w_sys;
    logic            w_illegal;
    logic            w_hazard;
    logic            w_accept;
    id2ex_t          w_dec;
    id2ex_t          r_q;

    assign w_opc = i_if2id_ins[6:0];
    assign w_f3  = i_if2id_ins[14:12];

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_ins (i_if2id_ins),
        .i_pc  (i_if2id_addr),
        .o_imm (w_imm)
    );

    always_comb begin
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_known   = 1'b1;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_csr     = '0;
        w_sys     = SYS_NONE;
        case (w_opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: w_use_rd = 1'b1;
            OPC_JALR, OPC_OPIMM: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OPC_OP: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_mem_rd  = 1'b1;
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_mem_wr  = 1'b1;
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_MISC_MEM: w_known = 1'b1;
            OPC_SYSTEM: begin
                if (w_f3 == F3_PRIV) begin
                    case (i_if2id_ins[31:7])
                        F25_MRET: begin
                            w_sys = SYS_MRET;
                            w_csr = MEPC_AR;
                        end
                        F25_ECALL:  w_sys = SYS_ECALL;
                        F25_EBREAK: w_sys = SYS_EBREAK;
                        default:    w_sys = SYS_NONE;
                    endcase
                end else begin
                    w_use_rd  = 1'b1;
                    w_use_rs1 = ~w_f3[2];
                    w_csr     = i_if2id_ins[31:20];
                end
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_illegal = ~w_known | f3_illegal(w_opc, w_f3);

    // Illegal words keep their raw opcode/funct fields so execute can trap
    always_comb begin
        w_dec        = '0;
        w_dec.valid  = 1'b1;
        w_dec.pc     = i_if2id_addr;
        w_dec.opcode = w_opc;
        w_dec.f3     = w_f3;
        w_dec.f7     = i_if2id_ins[31:25];
        if (w_illegal) begin
            w_dec.illegal = (ILLEGAL_EN != 0);
        end else begin
            w_dec.rd     = w_use_rd  ? i_if2id_ins[11:7]  : 5'd0;
            w_dec.rs1    = w_use_rs1 ? i_if2id_ins[19:15] : 5'd0;
            w_dec.rs2    = w_use_rs2 ? i_if2id_ins[24:20] : 5'd0;
            w_dec.imm    = w_imm;
            w_dec.mem_wr = w_mem_wr;
            w_dec.mem_rd = w_mem_rd;
            w_dec.reg_wr = w_use_rd && (i_if2id_ins[11:7] != 5'd0);
            w_dec.reg_rd = w_use_rs1 | w_use_rs2;
            w_dec.csr    = w_csr;
            w_dec.sys    = w_sys;
        end
    end

    generate
        if (HAZARD_EN != 0) begin : g_hazard_on
            // Unused source fields are already zero, so they never match a nonzero rd
            assign w_hazard = r_q.valid & r_q.mem_rd & (r_q.rd != 5'd0)
                            & ((r_q.rd == w_dec.rs1) | (r_q.rd == w_dec.rs2));
        end else begin : g_hazard_off
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign o_if2id_ready = i_wash_en | ((~r_q.valid | i_ex_ready) & ~w_hazard);
    assign w_accept      = i_if2id_valid & o_if2id_ready & ~i_wash_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_wash_en) begin
            r_q <= '0;
        end else if (~r_q.valid | i_ex_ready) begin
            r_q <= w_accept ? w_dec : '0;
        end
    end

    assign o_id2ex_valid     = r_q.valid;
    assign o_id2ex_pc        = r_q.pc;
    assign o_id2ex_op_code   = r_q.opcode;
    assign o_id2ex_rd_addr   = r_q.rd;
    assign o_id2ex_op0_addr  = r_q.rs1;
    assign o_id2ex_op1_addr  = r_q.rs2;
    assign o_id2ex_op_func3  = r_q.f3;
    assign o_id2ex_op_func7  = r_q.f7;
    assign o_id2ex_op_imm    = r_q.imm;
    assign o_id2ex_mem_wr_en = r_q.mem_wr;
    assign o_id2ex_mem_rd_en = r_q.mem_rd;
    assign o_id2ex_reg_wr_en = r_q.reg_wr;
    assign o_id2ex_reg_rd_en = r_q.reg_rd;
    assign o_id2ex_csr_addr  = r_q.csr;
    assign o_id2ex_sys       = r_q.sys;
    assign o_id2ex_illegal   = r_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_rv_id_pipe.sv
// ============================================================================
//  Module      : tb_rv_id_pipe
//  Description : Directed and randomized checks of rv_id_pipe against a
//                cycle-level behavioural model of the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_id_pipe;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        mw;
        logic        mr;
        logic        rw;
        logic        rr;
        logic [11:0] csr;
        logic [1:0]  sys;
        logic        ill;
    } bun_t;

    localparam logic [31:0] LW_X5  = 32'h00012283;
    localparam logic [31:0] ADD_X6 = 32'h00128333;
    localparam logic [31:0] ADDI_2 = 32'h00A00113;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_ins;
    logic        wash;
    logic        exr;

    logic        o_ready, o_valid, o_mw, o_mr, o_rw, o_rr, o_ill;
    logic [31:0] o_pc, o_imm;
    logic [6:0]  o_opc, o_f7;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_f3;
    logic [11:0] o_csr;
    logic [1:0]  o_sys;

    logic        n_ready, n_valid, n_mw, n_mr, n_rw, n_rr, n_ill;
    logic [31:0] n_pc, n_imm;
    logic [6:0]  n_opc, n_f7;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic [2:0]  n_f3;
    logic [11:0] n_csr;
    logic [1:0]  n_sys;

    bun_t obs, nobs, m, snap;
    logic o_rdy_s, n_rdy_s;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv_id_pipe #(.XLEN(32), .HAZARD_EN(1), .ILLEGAL_EN(1)) dut (
        .clk(clk), .rst(rst),
        .i_if2id_valid(in_valid), .o_if2id_ready(o_ready),
        .i_if2id_addr(in_addr), .i_if2id_ins(in_ins),
        .i_wash_en(wash), .i_ex_ready(exr),
        .o_id2ex_valid(o_valid), .o_id2ex_pc(o_pc), .o_id2ex_op_code(o_opc),
        .o_id2ex_rd_addr(o_rd), .o_id2ex_op0_addr(o_rs1), .o_id2ex_op1_addr(o_rs2),
        .o_id2ex_op_func3(o_f3), .o_id2ex_op_func7(o_f7), .o_id2ex_op_imm(o_imm),
        .o_id2ex_mem_wr_en(o_mw), .o_id2ex_mem_rd_en(o_mr),
        .o_id2ex_reg_wr_en(o_rw), .o_id2ex_reg_rd_en(o_rr),
        .o_id2ex_csr_addr(o_csr), .o_id2ex_sys(o_sys), .o_id2ex_illegal(o_ill)
    );

    rv_id_pipe #(.XLEN(32), .HAZARD_EN(0), .ILLEGAL_EN(1)) dut_nh (
        .clk(clk), .rst(rst),
        .i_if2id_valid(in_valid), .o_if2id_ready(n_ready),
        .i_if2id_addr(in_addr), .i_if2id_ins(in_ins),
        .i_wash_en(wash), .i_ex_ready(exr),
        .o_id2ex_valid(n_valid), .o_id2ex_pc(n_pc), .o_id2ex_op_code(n_opc),
        .o_id2ex_rd_addr(n_rd), .o_id2ex_op0_addr(n_rs1), .o_id2ex_op1_addr(n_rs2),
        .o_id2ex_op_func3(n_f3), .o_id2ex_op_func7(n_f7), .o_id2ex_op_imm(n_imm),
        .o_id2ex_mem_wr_en(n_mw), .o_id2ex_mem_rd_en(n_mr),
        .o_id2ex_reg_wr_en(n_rw), .o_id2ex_reg_rd_en(n_rr),
        .o_id2ex_csr_addr(n_csr), .o_id2ex_sys(n_sys), .o_id2ex_illegal(n_ill)
    );

    assign obs  = {o_valid, o_pc, o_opc, o_rd, o_rs1, o_rs2, o_f3, o_f7, o_imm,
                   o_mw, o_mr, o_rw, o_rr, o_csr, o_sys, o_ill};
    assign nobs = {n_valid, n_pc, n_opc, n_rd, n_rs1, n_rs2, n_f3, n_f7, n_imm,
                   n_mw, n_mr, n_rw, n_rr, n_csr, n_sys, n_ill};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input bun_t got, input bun_t exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural decode: classify the word, then assemble fields arithmetically
    function automatic bun_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
        bun_t        b;
        int unsigned u;
        int          imm, f3, sgn;
        bit          urd, urs1, urs2, bad, mw, mr;
        logic [11:0] csr;
        logic [1:0]  sys;
        logic [24:0] f25;
        u = ins; f3 = int'(ins[14:12]); sgn = int'(ins[31]); f25 = ins[31:7];
        imm = 0; urd = 0; urs1 = 0; urs2 = 0; bad = 0; mw = 0; mr = 0;
        csr = 12'h0; sys = 2'b00;
        b = '0; b.v = 1'b1; b.pc = pc; b.opc = ins[6:0]; b.f3 = ins[14:12]; b.f7 = ins[31:25];
        case (ins[6:0])
            7'h37: begin urd = 1; imm = int'(ins & 32'hFFFFF000); end
            7'h17: begin urd = 1; imm = int'((ins & 32'hFFFFF000) + pc); end
            7'h6F: begin
                urd = 1;
                imm = int'(((u >> 21) & 1023) * 2 + ((u >> 20) & 1) * 2048
                      + ((u >> 12) & 255) * 4096) - sgn * 1048576;
            end
            7'h67, 7'h13: begin urd = 1; urs1 = 1; imm = int'((u >> 20) & 4095) - sgn * 4096; end
            7'h33: begin urd = 1; urs1 = 1; urs2 = 1; end
            7'h03: begin
                urd = 1; urs1 = 1; mr = 1;
                imm = int'((u >> 20) & 4095) - sgn * 4096;
                bad = (f3 == 3) || (f3 >= 6);
            end
            7'h23: begin
                urs1 = 1; urs2 = 1; mw = 1;
                imm = int'(((u >> 25) & 127) * 32 + ((u >> 7) & 31)) - sgn * 4096;
                bad = (f3 >= 3);
            end
            7'h63: begin
                urs1 = 1; urs2 = 1;
                imm = int'(((u >> 8) & 15) * 2 + ((u >> 25) & 63) * 32 + ((u >> 7) & 1) * 2048)
                      - sgn * 4096;
                bad = (f3 == 2) || (f3 == 3);
            end
            7'h0F: bad = 0;
            7'h73: begin
                if (f3 == 0) begin
                    if (f25 == 25'h0604000) begin sys = 2'b01; csr = 12'h341; end
                    else if (f25 == 25'h0) sys = 2'b10;
                    else if (f25 == 25'h0002000) sys = 2'b11;
                end else if (f3 == 4) begin
                    bad = 1;
                end else begin
                    urd = 1; csr = ins[31:20];
                    if (f3 < 4) urs1 = 1;
                    else imm = int'((u >> 15) & 31);
                end
            end
            default: bad = 1;
        endcase
        if (bad) begin
            b.ill = 1'b1;
            return b;
        end
        b.rd  = urd  ? ins[11:7]  : 5'd0;
        b.rs1 = urs1 ? ins[19:15] : 5'd0;
        b.rs2 = urs2 ? ins[24:20] : 5'd0;
        b.imm = imm;
        b.mw  = mw;
        b.mr  = mr;
        b.rw  = (b.rd != 5'd0);
        b.rr  = urs1 | urs2;
        b.csr = csr;
        b.sys = sys;
        return b;
    endfunction

    // One clock of stimulus; checks ready mid-cycle and the bundle after the edge
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] ins,
                        input logic w, input logic er);
        bun_t d;
        logic haz, rdy;
        in_valid = v; in_addr = a; in_ins = ins; wash = w; exr = er;
        #1;
        d   = model_dec(ins, a);
        haz = m.v && m.mr && (m.rd != 5'd0) && ((d.rs1 == m.rd) || (d.rs2 == m.rd));
        rdy = w || ((!m.v || er) && !haz);
        o_rdy_s = o_ready;
        n_rdy_s = n_ready;
        chk("ready", 32'(o_ready), 32'(rdy));
        @(posedge clk);
        if (w) m = '0;
        else if (!m.v || er) m = (v && rdy) ? d : '0;
        #1;
        chk_b("bundle", obs, m);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  tbl [11];
        logic [31:0] r;
        int          k;
        tbl = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h0F, 7'h73};
        r = $urandom;
        k = int'($urandom_range(0, 13));
        if (k < 11) r[6:0] = tbl[k];
        r[11:7]  = 5'($urandom_range(0, 4));
        r[19:15] = 5'($urandom_range(0, 4));
        r[24:20] = 5'($urandom_range(0, 4));
        if (r[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, 2));
            r = (k == 0) ? 32'h30200073 : (k == 1) ? 32'h00000073 : 32'h00100073;
        end
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_ins = '0; wash = 1'b0; exr = 1'b1;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_bundle", obs, '0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        rst = 1'b0;

        step(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b1);
        chk("addi_valid", 32'(o_valid), 32'd1);
        chk("addi_rd", 32'(o_rd), 32'd1);
        chk("addi_op0", 32'(o_rs1), 32'd0);
        chk("addi_imm", o_imm, 32'd5);
        chk("addi_wr", 32'(o_rw), 32'd1);
        chk("addi_pc", o_pc, 32'h100);

        step(1'b1, 32'h200, 32'hFFDFF0EF, 1'b0, 1'b1);
        chk("jal_imm", o_imm, 32'hFFFFFFFC);
        step(1'b1, 32'h204, 32'h00000463, 1'b0, 1'b1);
        chk("beq_imm", o_imm, 32'd8);
        step(1'b1, 32'h1000, 32'h12345097, 1'b0, 1'b1);
        chk("auipc_imm", o_imm, 32'h12346000);

        // load-use: both instances start empty after the flush
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h300, LW_X5, 1'b0, 1'b1);
        step(1'b1, 32'h304, ADD_X6, 1'b0, 1'b1);
        chk("lu_ready", 32'(o_rdy_s), 32'd0);
        chk("lu_bubble", 32'(o_valid), 32'd0);
        chk("nh_ready", 32'(n_rdy_s), 32'd1);
        chk("nh_add_valid", 32'(nobs.v), 32'd1);
        chk("nh_add_rd", 32'(nobs.rd), 32'd6);
        step(1'b1, 32'h304, ADD_X6, 1'b0, 1'b1);
        chk("lu_ready_after", 32'(o_rdy_s), 32'd1);
        chk("lu_add_rd", 32'(o_rd), 32'd6);
        chk("lu_add_pc", o_pc, 32'h304);

        step(1'b1, 32'h400, ADDI_2, 1'b0, 1'b1);
        snap = obs;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h404, 32'h00100193, 1'b0, 1'b0);
            chk_b("bp_hold", obs, snap);
            chk("bp_ready", 32'(o_rdy_s), 32'd0);
        end
        step(1'b1, 32'h404, 32'h00100193, 1'b0, 1'b1);
        chk("bp_release_pc", o_pc, 32'h404);

        step(1'b1, 32'h500, LW_X5, 1'b0, 1'b1);
        step(1'b1, 32'h504, ADD_X6, 1'b1, 1'b1);
        chk("fl_ready", 32'(o_rdy_s), 32'd1);
        chk_b("fl_clear", obs, '0);
        step(1'b1, 32'h504, ADD_X6, 1'b0, 1'b1);
        chk("fl_no_stall", 32'(o_rdy_s), 32'd1);
        chk("fl_add_valid", 32'(o_valid), 32'd1);

        step(1'b1, 32'h600, 32'h30200073, 1'b0, 1'b1);
        chk("mret_sys", 32'(o_sys), 32'd1);
        chk("mret_csr", 32'(o_csr), 32'h341);
        chk("mret_wr", 32'(o_rw), 32'd0);
        step(1'b1, 32'h604, 32'h0000007F, 1'b0, 1'b1);
        chk("ill_flag", 32'(o_ill), 32'd1);
        chk("ill_valid", 32'(o_valid), 32'd1);
        chk("ill_enables", 32'({o_mw, o_mr, o_rw, o_rr}), 32'd0);

        // reset in the middle of a backpressure stall
        step(1'b1, 32'h700, LW_X5, 1'b0, 1'b1);
        step(1'b1, 32'h704, ADDI_2, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_b("rst_mid", obs, '0);
        m = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 32'h708, ADDI_2, 1'b0, 1'b1);
        chk("rst_mid_resume_pc", o_pc, 32'h708);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFFFFFC, rand_ins(),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
